// File: rtl/dump_pkg.sv
// Shared tags, FSM encoding and END-word layout for the run/dump sequencer.
package dump_pkg;

  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_REG = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;
  localparam logic [1:0] TAG_END = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_REGS,
    ST_MEMS,
    ST_ENDW,
    ST_DONE
  } state_t;

  // END word: MSB carries the trace overflow flag, low bits the zero-extended cycle count.
  localparam int END_CNT_LSB = 0;

  function automatic logic [1:0] tag_for(input state_t s);
    case (s)
      ST_REGS: tag_for = TAG_REG;
      ST_MEMS: tag_for = TAG_MEM;
      ST_ENDW: tag_for = TAG_END;
      default: tag_for = TAG_PC;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO holding the PC trace; DEPTH must be a power of 2.
module trace_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] store [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       used;
  logic              do_push;
  logic              do_pop;

  assign full    = (used == (AW+1)'(DEPTH));
  assign empty   = (used == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = store[rptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      used <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      used <= used + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/run_dump_sequencer.sv
// End-of-run monitor: detects halt/timeout, then streams REG, MEM and END words.
// Optional PC trace stream (tag 0) is built when TRACE_PC_EN is defined.
module run_dump_sequencer
  import dump_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          NUM_REGS    = 32,
  parameter int unsigned MEM_BASE    = 'h4000,
  parameter int          MEM_WORDS   = 4,
  parameter int          MAX_CYCLES  = 64,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DATA_W-1:0]           pc,
  input  logic [DATA_W-1:0]           inst,
  output logic [$clog2(NUM_REGS)-1:0] rf_raddr,
  input  logic [DATA_W-1:0]           rf_rdata,
  output logic [DATA_W-1:0]           mem_raddr,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        dump_valid,
  input  logic                        dump_ready,
  output logic [DATA_W-1:0]           dump_data,
  output logic [1:0]                  dump_tag,
  output logic                        done,
  output logic                        timeout
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int JW = $clog2(MEM_WORDS + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     ri;
  logic [JW-1:0]     mj;
  logic [JW-1:0]     mj_next;
  logic              mprimed;
  logic              accept;
  logic              overflow;
  logic              drain_done;
  logic              trace_valid;
  logic [DATA_W-1:0] trace_data;
  logic [DATA_W-1:0] end_word;

  assign accept   = dump_valid && dump_ready;
  assign rf_raddr = ri;

  // Memory address runs one word ahead on accept so mem_rdata keeps pace at 1 word/cycle;
  // while stalled the address is held, so the returned word stays stable.
  assign mj_next   = mj + ((state == ST_MEMS && accept) ? JW'(1) : JW'(0));
  assign mem_raddr = DATA_W'(MEM_BASE) + DATA_W'(mj_next);

`ifdef TRACE_PC_EN
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  logic trace_phase;

  assign trace_phase = (state == ST_RUN) || (state == ST_DRAIN);
  assign fifo_push   = (state == ST_RUN);
  assign fifo_pop    = trace_phase && accept;
  assign trace_valid = trace_phase && !fifo_empty;
  assign drain_done  = fifo_empty;

  trace_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (pc),
    .pop   (fifo_pop),
    .rdata (trace_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            overflow <= 1'b0;
    else if (state == ST_RUN && fifo_full) overflow <= 1'b1;
  end
`else
  localparam int unused_trace_depth = TRACE_DEPTH;
  logic unused_pc;

  assign unused_pc   = ^pc;
  assign overflow    = 1'b0;
  assign drain_done  = 1'b1;
  assign trace_valid = 1'b0;
  assign trace_data  = '0;
`endif

  always_comb begin
    end_word = '0;
    end_word[END_CNT_LSB +: CW] = cnt;
    end_word[DATA_W-1] = overflow;
  end

  always_comb begin
    dump_valid = 1'b0;
    dump_data  = '0;
    dump_tag   = tag_for(state);
    case (state)
      ST_RUN, ST_DRAIN: begin
        dump_valid = trace_valid;
        dump_data  = trace_data;
      end
      ST_REGS: begin
        dump_valid = 1'b1;
        dump_data  = rf_rdata;
      end
      ST_MEMS: begin
        dump_valid = mprimed;
        dump_data  = mem_rdata;
      end
      ST_ENDW: begin
        dump_valid = 1'b1;
        dump_data  = end_word;
      end
      default: ;
    endcase
  end

  // inst==0 is tested before the budget so a simultaneous halt never reports timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ri      <= '0;
      mj      <= '0;
      mprimed <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (inst == '0) begin
            state <= ST_DRAIN;
          end else if (cnt == CW'(MAX_CYCLES - 1)) begin
            state   <= ST_DRAIN;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_REGS;
            ri    <= '0;
          end
        end
        ST_REGS: begin
          if (accept) begin
            if (ri == RW'(NUM_REGS - 1)) begin
              state   <= ST_MEMS;
              mj      <= '0;
              mprimed <= 1'b0;
            end else begin
              ri <= ri + 1'b1;
            end
          end
        end
        ST_MEMS: begin
          mprimed <= 1'b1;
          mj      <= mj_next;
          if (accept && mj == JW'(MEM_WORDS - 1)) state <= ST_ENDW;
        end
        ST_ENDW: begin
          if (accept) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_dump_sequencer.sv
// Directed bench for run_dump_sequencer: scenario table plus a mid-dump reset sequence.
module tb_run_dump_sequencer;
  import dump_pkg::*;

  localparam logic [31:0] NZ     = 32'h0000_0013;
  localparam int          BUDGET = 400;

  typedef struct {
    int halt_at;
    int rmode;
    int exp_cnt;
    int exp_timeout;
    int exp_ovf;
    int exp_npc;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [1:0]  dump_tag;
  logic        done;
  logic        timeout;

  int   n_checks;
  int   n_fail;
  vec_t vecs[6];

  run_dump_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pc         (pc),
    .inst       (inst),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_tag   (dump_tag),
    .done       (done),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file reads combinationally; data memory returns one cycle after the address.
  assign rf_rdata = 32'hA500_0000 | 32'(rf_raddr);

  initial mem_rdata = '0;
  always @(posedge clk) mem_rdata <= {16'hBEEF, mem_raddr[15:0]};

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int abort_at);
    int          w;
    int          n_pc;
    logic        have_hold;
    logic [33:0] held;
    logic [1:0]  etag;
    logic [31:0] edata;
    w = 0;
    n_pc = 0;
    have_hold = 1'b0;
    held = '0;
    start = 1'b1;
    inst = NZ;
    dump_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      inst  = (cyc == v.halt_at) ? 32'h0 : NZ;
      pc    = 32'h100 + 32'(cyc) * 4;
      start = (cyc == 20);
      case (v.rmode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (cyc < 10) || (cyc % 2 == 0);
        default: dump_ready = (cyc >= 12);
      endcase
      #1;
      if (done) break;
      if (have_hold)
        checkOutput("stall_hold", {29'd0, dump_valid, dump_tag, dump_data}, {29'd0, 1'b1, held});
      if (dump_valid && dump_ready) begin
        if (dump_tag == TAG_PC) begin
          checkOutput($sformatf("pc%0d", n_pc), 64'(dump_data), 64'(32'h100 + 32'(n_pc) * 4));
          n_pc++;
        end else if (w > 36) begin
          checkOutput("extra_word", 64'(w), 64'd36);
          w++;
        end else begin
          if (w < 32) begin
            etag  = TAG_REG;
            edata = 32'hA500_0000 | 32'(w);
          end else if (w < 36) begin
            etag  = TAG_MEM;
            edata = 32'hBEEF_0000 | (32'h4000 + 32'(w - 32));
          end else begin
            etag  = TAG_END;
            edata = {v.exp_ovf[0], 31'(v.exp_cnt)};
          end
          checkOutput($sformatf("word%0d", w), {30'd0, dump_tag, dump_data}, {30'd0, etag, edata});
          w++;
        end
      end
      have_hold = dump_valid && !dump_ready;
      held = {dump_tag, dump_data};
      if (abort_at >= 0 && w == abort_at) break;
      @(negedge clk);
    end
    if (abort_at < 0) begin
      checkOutput("done", 64'(done), 64'd1);
      checkOutput("timeout", 64'(timeout), 64'(v.exp_timeout));
      checkOutput("word_count", 64'(w), 64'd37);
      checkOutput("pc_word_count", 64'(n_pc), 64'(v.exp_npc));
      checkOutput("valid_after_done", 64'(dump_valid), 64'd0);
    end
  endtask

  initial begin
    vecs[0] = '{halt_at: 5,  rmode: 0, exp_cnt: 5,  exp_timeout: 0, exp_ovf: 0, exp_npc: 0};
    vecs[1] = '{halt_at: -1, rmode: 0, exp_cnt: 63, exp_timeout: 1, exp_ovf: 0, exp_npc: 0};
    vecs[2] = '{halt_at: 63, rmode: 0, exp_cnt: 63, exp_timeout: 0, exp_ovf: 0, exp_npc: 0};
    vecs[3] = '{halt_at: 4,  rmode: 1, exp_cnt: 4,  exp_timeout: 0, exp_ovf: 0, exp_npc: 0};
    vecs[4] = '{halt_at: 11, rmode: 2, exp_cnt: 11, exp_timeout: 0, exp_ovf: 0, exp_npc: 0};
    vecs[5] = '{halt_at: 0,  rmode: 0, exp_cnt: 0,  exp_timeout: 0, exp_ovf: 0, exp_npc: 0};
`ifdef TRACE_PC_EN
    vecs[0].exp_npc = 6;
    vecs[1].exp_npc = 64;
    vecs[2].exp_npc = 64;
    vecs[3].exp_npc = 5;
    vecs[4].exp_npc = 8;
    vecs[4].exp_ovf = 1;
    vecs[5].exp_npc = 1;
`endif

    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    start = 1'b0;
    pc = '0;
    inst = NZ;
    dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_valid", 64'(dump_valid), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_timeout", 64'(timeout), 64'd0);
    checkOutput("reset_rf_raddr", 64'(rf_raddr), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] scenario %0d: halt_at=%0d ready_mode=%0d", i, vecs[i].halt_at, vecs[i].rmode);
      pulseReset();
      applyStimulus(vecs[i], -1);
    end

    // Reset while the register dump sits at r10, then a fresh run must start again at r0.
    $display("[TB] reset during register dump");
    pulseReset();
    applyStimulus(vecs[0], 10);
    @(posedge clk);
    @(negedge clk);
    dump_ready = 1'b0;
    #1;
    checkOutput("mid_rf_raddr", 64'(rf_raddr), 64'd10);
    checkOutput("mid_word", {30'd0, dump_tag, dump_data}, {30'd0, TAG_REG, 32'hA500_000A});
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_valid", 64'(dump_valid), 64'd0);
    checkOutput("mid_reset_rf_raddr", 64'(rf_raddr), 64'd0);
    checkOutput("mid_reset_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("idle_after_reset_valid", 64'(dump_valid), 64'd0);
    @(negedge clk);
    applyStimulus(vecs[3], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
